// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one multi-cycle multiplier among NREQ requesters.
// Optional WAIT-state timeout enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_share_arb #(
   parameter int WIDTH_M = 8,
   parameter int WIDTH_R = 8,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NREQ-1:0]            req_vld,
   output logic [NREQ-1:0]            req_rdy,
   input  logic [NREQ*WIDTH_M-1:0]    req_a,
   input  logic [NREQ*WIDTH_R-1:0]    req_b,
   output logic [NREQ-1:0]            rsp_vld,
   input  logic [NREQ-1:0]            rsp_rdy,
   output logic [WIDTH_M+WIDTH_R-1:0] rsp_data,
   output logic                       rsp_err,
   output logic                       mul_vld_in,
   output logic [WIDTH_M-1:0]         mul_multiplicand,
   output logic [WIDTH_R-1:0]         mul_multiplier,
   input  logic [WIDTH_M+WIDTH_R-1:0] mul_out,
   input  logic                       mul_done,
   output logic                       busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WP = WIDTH_M + WIDTH_R;

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
      $error("mul_share_arb: unsupported NREQ/TIMEOUT");
   end

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t state, state_nx;

   logic [IW-1:0]      last_grant;
   logic [IW-1:0]      grant_idx;
   logic [IW-1:0]      win_idx;
   logic [NREQ-1:0]    win_oh;
   logic               win_any;
   logic [WIDTH_M-1:0] a_sel;
   logic [WIDTH_R-1:0] b_sel;
   logic [WIDTH_M-1:0] op_a;
   logic [WIDTH_R-1:0] op_b;
   logic [WP-1:0]      data_q;
   logic               accept;
   logic               tmo_ev;

   // Search starts one past the last winner and wraps.
   always_comb begin : rr_pick
      int j;
      j       = 0;
      win_oh  = '0;
      win_idx = '0;
      win_any = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         j = int'(last_grant) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!win_any && req_vld[j]) begin
            win_any    = 1'b1;
            win_oh[j]  = 1'b1;
            win_idx    = IW'(j);
         end
      end
   end

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) begin
            a_sel = req_a[i*WIDTH_M +: WIDTH_M];
            b_sel = req_b[i*WIDTH_R +: WIDTH_R];
         end
      end
   end

   assign accept = (state == IDLE) && win_any;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wait_cnt;
   logic          err_q;

   assign tmo_ev = (state == WAIT) && !mul_done &&
                   (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wait_cnt <= '0;
      end else if (state != WAIT) begin
         wait_cnt <= '0;
      end else if (!tmo_ev) begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_q <= 1'b0;
      end else if (state == WAIT) begin
         if (mul_done) err_q <= 1'b0;
         else if (tmo_ev) err_q <= 1'b1;
      end
   end

   assign rsp_err = err_q;
`else
   assign tmo_ev  = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (mul_done || tmo_ev) state_nx = RESP;
         RESP:    if (rsp_rdy[grant_idx]) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_a       <= '0;
         op_b       <= '0;
         grant_idx  <= '0;
         last_grant <= IW'(NREQ - 1);
         data_q     <= '0;
      end else begin
         if (accept) begin
            op_a       <= a_sel;
            op_b       <= b_sel;
            grant_idx  <= win_idx;
            last_grant <= win_idx;
         end
         if (state == WAIT) begin
            if (mul_done) data_q <= mul_out;
            else if (tmo_ev) data_q <= '0;
         end
      end
   end

   always_comb begin
      rsp_vld = '0;
      if (state == RESP) rsp_vld[grant_idx] = 1'b1;
   end

   assign req_rdy          = (state == IDLE) ? win_oh : '0;
   assign mul_vld_in       = (state == ISSUE);
   assign mul_multiplicand = op_a;
   assign mul_multiplier   = op_b;
   assign rsp_data         = data_q;
   assign busy             = (state != IDLE);

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed vector bench for mul_share_arb with a one-cycle signed multiplier model.
// Timeout checks follow MUL_ARB_TIMEOUT_EN when it is defined.
module tb_mul_share_arb;

   localparam int NREQ = 4;
   localparam int WM   = 8;
   localparam int WR   = 8;
   localparam int WP   = WM + WR;

   logic              clk;
   logic              rstn;
   logic [NREQ-1:0]   req_vld;
   logic [NREQ-1:0]   req_rdy;
   logic [NREQ*WM-1:0] req_a;
   logic [NREQ*WR-1:0] req_b;
   logic [NREQ-1:0]   rsp_vld;
   logic [NREQ-1:0]   rsp_rdy;
   logic [WP-1:0]     rsp_data;
   logic              rsp_err;
   logic              mul_vld_in;
   logic [WM-1:0]     mul_multiplicand;
   logic [WR-1:0]     mul_multiplier;
   logic [WP-1:0]     mul_out;
   logic              mul_done;
   logic              busy;

   logic              mdone_m;
   logic              inj_done;
   logic              model_en;
   logic              pend;
   logic [WP-1:0]     prod;

   int n_vec;
   int n_err;

   typedef struct {
      int          idx;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      int          hold;
   } vec_t;

   vec_t tbl[6];

   mul_share_arb #(
      .WIDTH_M(WM),
      .WIDTH_R(WR),
      .NREQ(NREQ),
      .TIMEOUT(16)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .req_vld(req_vld),
      .req_rdy(req_rdy),
      .req_a(req_a),
      .req_b(req_b),
      .rsp_vld(rsp_vld),
      .rsp_rdy(rsp_rdy),
      .rsp_data(rsp_data),
      .rsp_err(rsp_err),
      .mul_vld_in(mul_vld_in),
      .mul_multiplicand(mul_multiplicand),
      .mul_multiplier(mul_multiplier),
      .mul_out(mul_out),
      .mul_done(mul_done),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mul_done = mdone_m | inj_done;

   // Signed Booth multiplier stand-in: done one cycle after the start pulse.
   initial begin
      mdone_m = 1'b0;
      pend    = 1'b0;
      prod    = '0;
      mul_out = '0;
   end

   always @(posedge clk) begin
      #1;
      mdone_m = 1'b0;
      if (!rstn) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            mdone_m = 1'b1;
            mul_out = prod;
            pend    = 1'b0;
         end
         if (mul_vld_in && model_en) begin
            pend = 1'b1;
            prod = $signed({{WR{mul_multiplicand[WM-1]}}, mul_multiplicand}) *
                   $signed({{WM{mul_multiplier[WR-1]}}, mul_multiplier});
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_rsp(input int maxc, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         if (rsp_vld != '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic handshake(input int idx);
      @(posedge clk); #1;
      rsp_rdy = 4'(1 << idx);
      @(negedge clk);
      chk("hs_rsp_vld", rsp_vld, 1 << idx);
      @(posedge clk); #1;
      rsp_rdy = '0;
      @(negedge clk);
      chk("hs_idle_busy", busy, 0);
      chk("hs_idle_rsp_vld", rsp_vld, 0);
   endtask

   task automatic run_one(input vec_t v);
      logic [3:0] oh;
      oh = 4'(1 << v.idx);
      @(posedge clk); #1;
      req_vld = oh;
      req_a[v.idx*WM +: WM] = v.a;
      req_b[v.idx*WR +: WR] = v.b;
      @(negedge clk);
      chk("acc_req_rdy", req_rdy, oh);
      chk("acc_busy", busy, 0);
      @(posedge clk); #1;
      req_vld = (v.hold > 0) ? oh : '0;
      @(negedge clk);
      chk("iss_mul_vld", mul_vld_in, 1);
      chk("iss_mcand", mul_multiplicand, v.a);
      chk("iss_mplier", mul_multiplier, v.b);
      chk("iss_req_rdy", req_rdy, 0);
      @(negedge clk);
      chk("wait_mul_vld", mul_vld_in, 0);
      chk("wait_rsp_vld", rsp_vld, 0);
      @(negedge clk);
      chk("rsp_vld", rsp_vld, oh);
      chk("rsp_data", rsp_data, v.p);
      chk("rsp_err", rsp_err, 0);
      chk("rsp_busy", busy, 1);
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk); #1;
         rsp_rdy = ~oh;
         @(negedge clk);
         chk("hold_rsp_vld", rsp_vld, oh);
         chk("hold_rsp_data", rsp_data, v.p);
         chk("hold_req_rdy", req_rdy, 0);
      end
      @(posedge clk); #1;
      req_vld = '0;
      rsp_rdy = oh;
      @(negedge clk);
      chk("hs_rsp_vld", rsp_vld, oh);
      @(posedge clk); #1;
      rsp_rdy = '0;
      @(negedge clk);
      chk("hs_idle_busy", busy, 0);
      chk("hs_idle_rsp_vld", rsp_vld, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  order[5];
      int  g;
      int  dbl;
      bit  prev_mv;
      bit  ok;

      n_vec    = 0;
      n_err    = 0;
      rstn     = 1'b0;
      req_vld  = '0;
      req_a    = '0;
      req_b    = '0;
      rsp_rdy  = '0;
      inj_done = 1'b0;
      model_en = 1'b1;

      tbl[0] = '{idx: 0, a: 8'd3,   b: 8'd5,   p: 16'd15,    hold: 0};
      tbl[1] = '{idx: 2, a: 8'hFD,  b: 8'd7,   p: 16'hFFEB,  hold: 5};
      tbl[2] = '{idx: 1, a: 8'h80,  b: 8'h80,  p: 16'h4000,  hold: 0};
      tbl[3] = '{idx: 3, a: 8'hFF,  b: 8'hFF,  p: 16'h0001,  hold: 1};
      tbl[4] = '{idx: 0, a: 8'h7F,  b: 8'h80,  p: 16'hC080,  hold: 0};
      tbl[5] = '{idx: 1, a: 8'h00,  b: 8'h55,  p: 16'h0000,  hold: 2};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_mul_vld", mul_vld_in, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_mcand", mul_multiplicand, 0);
      rstn = 1'b1;

      // All requesters active, responses always accepted.
      @(posedge clk); #1;
      req_a   = {8'd4, 8'd3, 8'd2, 8'd1};
      req_b   = {8'd8, 8'd7, 8'd6, 8'd5};
      req_vld = 4'hF;
      rsp_rdy = 4'hF;
      g       = 0;
      dbl     = 0;
      prev_mv = 1'b0;
      for (int c = 0; c < 60 && g < 5; c++) begin
         @(negedge clk);
         if (mul_vld_in && prev_mv) dbl++;
         prev_mv = mul_vld_in;
         if (req_rdy != '0) begin
            for (int i = 0; i < NREQ; i++)
               if (req_rdy[i]) order[g] = i;
            g++;
         end
      end
      @(posedge clk); #1;
      req_vld = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mul_vld_in && prev_mv) dbl++;
         prev_mv = mul_vld_in;
         if (!busy) break;
      end
      chk("rr_grant_count", g, 5);
      chk("rr_grant0", order[0], 0);
      chk("rr_grant1", order[1], 1);
      chk("rr_grant2", order[2], 2);
      chk("rr_grant3", order[3], 3);
      chk("rr_grant4", order[4], 0);
      chk("rr_single_pulse", dbl, 0);
      chk("rr_drained", busy, 0);
      @(posedge clk); #1;
      rsp_rdy = '0;
      req_a   = '0;
      req_b   = '0;

      for (int i = 0; i < 6; i++) run_one(tbl[i]);

      // Reset while waiting on the multiplier.
      @(posedge clk); #1;
      model_en = 1'b0;
      req_a[0 +: WM] = 8'd9;
      req_b[0 +: WR] = 8'd9;
      req_vld = 4'b0001;
      @(negedge clk);
      chk("rw_req_rdy", req_rdy, 4'b0001);
      @(posedge clk); #1;
      req_vld = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rw_in_wait", busy, 1);
      rstn = 1'b0;
      #1;
      chk("rw_busy", busy, 0);
      chk("rw_mul_vld", mul_vld_in, 0);
      chk("rw_mcand", mul_multiplicand, 0);
      chk("rw_mplier", mul_multiplier, 0);
      chk("rw_rsp_vld", rsp_vld, 0);
      chk("rw_rsp_data", rsp_data, 0);
      chk("rw_req_rdy", req_rdy, 0);
      @(negedge clk);
      rstn     = 1'b1;
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      chk("rw_late_done_busy", busy, 0);
      chk("rw_late_done_rsp", rsp_vld, 0);
      @(posedge clk); #1;
      model_en = 1'b1;
      req_a[1*WM +: WM] = 8'd6;
      req_b[1*WR +: WR] = 8'd7;
      req_vld = 4'b1010;
      @(negedge clk);
      chk("rw_first_grant", req_rdy, 4'b0010);
      @(posedge clk); #1;
      req_vld = '0;
      wait_rsp(10, ok);
      chk("rw_rsp_seen", ok, 1);
      chk("rw_rsp_vld", rsp_vld, 4'b0010);
      chk("rw_rsp_data", rsp_data, 16'd42);
      handshake(1);

      // Multiplier never completes.
      @(posedge clk); #1;
      model_en = 1'b0;
      req_a[0 +: WM] = 8'd1;
      req_b[0 +: WR] = 8'd1;
      req_vld = 4'b0001;
      @(posedge clk); #1;
      req_vld = '0;
      @(negedge clk);
      chk("to_issue", mul_vld_in, 1);
`ifdef MUL_ARB_TIMEOUT_EN
      dbl = 0;
      for (int w = 0; w < 16; w++) begin
         @(negedge clk);
         if (rsp_vld != '0) dbl++;
      end
      chk("to_early_rsp", dbl, 0);
      @(negedge clk);
      chk("to_rsp_vld", rsp_vld, 4'b0001);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_data", rsp_data, 0);
      handshake(0);
`else
      repeat (1000) @(negedge clk);
      chk("to_still_busy", busy, 1);
      chk("to_no_rsp", rsp_vld, 0);
      chk("to_rsp_err", rsp_err, 0);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("to_recover_idle", busy, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mul_share_arb.md
MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
REQ-001 Parameter WIDTH_M, 8, multiplicand width.
REQ-002 Parameter WIDTH_R, 8, multiplier width.
REQ-003 Parameter NREQ, 4, number of requesters (2..8).
REQ-004 Parameter TIMEOUT, 64, WAIT-state cycle limit (used only with MUL_ARB_TIMEOUT_EN).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 req_vld  in  NREQ  per-requester operand valid.
REQ-008 req_rdy  out  NREQ  per-requester accept, one-hot or zero.
REQ-009 req_a  in  NREQ*WIDTH_M  packed multiplicands; requester i occupies slice i.
REQ-010 req_b  in  NREQ*WIDTH_R  packed multipliers; requester i occupies slice i.
REQ-011 rsp_vld  out  NREQ  per-requester result valid, one-hot or zero.
REQ-012 rsp_rdy  in  NREQ  per-requester result accept.
REQ-013 rsp_data  out  WIDTH_M+WIDTH_R  shared result bus.
REQ-014 rsp_err  out  1  result is a timeout error, qualified by rsp_vld.
REQ-015 mul_vld_in  out  1  start pulse to the shared Booth multiplier.
REQ-016 mul_multiplicand  out  WIDTH_M  operand to multiplier.
REQ-017 mul_multiplier  out  WIDTH_R  operand to multiplier.
REQ-018 mul_out  in  WIDTH_M+WIDTH_R  multiplier product.
REQ-019 mul_done  in  1  multiplier completion strobe.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: req_rdy is combinationally the one-hot round-robin winner among req_vld; zero if req_vld is zero.
REQ-023 Round-robin: priority starts at last_grant+1 and wraps modulo NREQ; last_grant updates on each accept.
REQ-024 Accept (req_vld[i] & req_rdy[i]) in IDLE: register operands slice i and index i; IDLE->ISSUE.
REQ-025 req_rdy is zero in ISSUE, WAIT and RESP; at most one operation is outstanding.
REQ-026 ISSUE: mul_vld_in=1 for exactly one cycle with the registered operands; ISSUE->WAIT.
REQ-027 mul_multiplicand/mul_multiplier hold the registered operands from ISSUE until the next accept.
REQ-028 WAIT: on mul_done=1, register mul_out into rsp_data, clear rsp_err; WAIT->RESP.
REQ-029 mul_done is ignored in IDLE, ISSUE and RESP.
REQ-030 RESP: rsp_vld[granted]=1; rsp_data and rsp_err stable; on rsp_rdy[granted]=1, RESP->IDLE; rsp_rdy of other indices is ignored.
REQ-031 Minimum latency, with mul_done one cycle after mul_vld_in: accept at cycle T, mul_vld_in at T+1, rsp_vld at T+3; next accept at the earliest in the cycle after the rsp handshake.
REQ-032 rsp_data is a bit-exact pass-through of mul_out; no sign or width modification.

Reset
REQ-033 rstn low forces, asynchronously: state=IDLE, last_grant=NREQ-1 (requester 0 is first priority), and all registered outputs zero.
REQ-034 Reset mid-operation drops the in-flight operation with no response; a later mul_done is ignored per REQ-029.

Configuration
REQ-035 Macro MUL_ARB_TIMEOUT_EN defined: a WAIT counter counts from 0; on TIMEOUT cycles without mul_done, set rsp_data=0 and rsp_err=1, WAIT->RESP.
REQ-036 Macro absent: no counter; WAIT persists until mul_done; rsp_err is tied to 0.

Verification
REQ-037 Only req_vld[0], a=3, b=5, 1-cycle multiplier model: rsp_vld[0] at T+3, rsp_data=15, rsp_err=0, busy high T+1..T+3.
REQ-038 All four req_vld high from reset, rsp_rdy tied high: grants in order 0,1,2,3,0; each mul_vld_in is a single-cycle pulse.
REQ-039 Requester 2 only, a=8'hFD, b=7, rsp_rdy[2] held low 5 cycles: rsp_vld[2] and rsp_data=16'hFFEB held stable; req_rdy stays 0 until the handshake.
REQ-040 rstn pulsed low in WAIT: all outputs 0 immediately; a late mul_done is ignored; after release with req_vld=4'b1010, requester 1 is granted first.
REQ-041 MUL_ARB_TIMEOUT_EN, TIMEOUT=16, mul_done never asserted: RESP after 16 WAIT cycles with rsp_err=1 and rsp_data=0. Without the macro, the FSM is still in WAIT after 1000 cycles and rsp_err=0.
